// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR engine sequencer (ap handshake, sample count,
// circular data-buffer and tap addressing, MAC and stream control).
// Ports: ACLK/ARESET (sync, active-low); ap_start, data_length,
// ap_idle, ap_done; ss_valid/ss_ready input stream; data_we,
// data_zero, data_a, tap_a BRAM control; mac_en, mac_clr MAC control;
// y_valid, sm_ready, y_last result stream.
module fir_seq_ctrl #(
  parameter int NUM_TAPS   = 11,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ss_valid,
  output logic                  ss_ready,
  output logic                  data_we,
  output logic                  data_zero,
  output logic [ADDR_WIDTH-1:0] data_a,
  output logic [ADDR_WIDTH-1:0] tap_a,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  y_valid,
  input  logic                  sm_ready,
  output logic                  y_last
);

  localparam int IW =
    (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] hp;
  logic [IW-1:0] rd;
  logic [31:0]   len;
  logic [31:0]   cnt;
  logic [31:0]   cnt_nx;

  function automatic logic [ADDR_WIDTH-1:0]
    baddr(input logic [IW-1:0] i);
    return ADDR_WIDTH'({i, 2'b00});
  endfunction

  assign cnt_nx = cnt + 32'd1;

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      state   <= IDLE;
      idx     <= '0;
      hp      <= '0;
      rd      <= '0;
      len     <= '0;
      cnt     <= '0;
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      // Issue strobe delayed one cycle for the BRAM read latency.
      mac_en  <= (state == MAC);
      mac_clr <= (state == MAC) && (idx == '0);
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            len     <= data_length;
            cnt     <= '0;
            hp      <= '0;
            idx     <= '0;
            ap_done <= 1'b0;
            ap_idle <= 1'b0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= (len == '0) ? DONE : WAIT_IN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        WAIT_IN: begin
          if (ss_valid) begin
            idx   <= '0;
            rd    <= hp;
            state <= MAC;
          end
        end
        MAC: begin
          // Walk backwards from the newest sample, wrapping below 0.
          rd <= (rd == '0) ? LAST : rd - IW'(1);
          if (idx == LAST) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DRAIN: begin
          state <= OUT;
        end
        OUT: begin
          if (sm_ready) begin
            cnt   <= cnt_nx;
            hp    <= (hp == LAST) ? '0 : hp + IW'(1);
            state <= (cnt_nx == len) ? DONE : WAIT_IN;
          end
        end
        DONE: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ss_ready  = (state == WAIT_IN);
  assign data_zero = (state == CLEAR);
  assign data_we   = (state == CLEAR) ||
                     ((state == WAIT_IN) && ss_valid);
  assign tap_a     = (state == MAC) ? baddr(idx) : '0;
  assign y_valid   = (state == OUT);
  assign y_last    = (state == OUT) && (cnt_nx == len);

  always_comb begin
    data_a = '0;
    unique case (1'b1)
      (state == CLEAR):   data_a = baddr(idx);
      (state == WAIT_IN): data_a = baddr(hp);
      (state == MAC):     data_a = baddr(rd);
      default:            data_a = '0;
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed bench for fir_seq_ctrl with NUM_TAPS=11.
// Drives start/stream handshakes and checks addresses and strobes.
module tb_fir_seq_ctrl;

  localparam int N = 11;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        ap_start = 1'b0;
  logic [31:0] data_length = '0;
  logic        ap_idle;
  logic        ap_done;
  logic        ss_valid = 1'b0;
  logic        ss_ready;
  logic        data_we;
  logic        data_zero;
  logic [11:0] data_a;
  logic [11:0] tap_a;
  logic        mac_en;
  logic        mac_clr;
  logic        y_valid;
  logic        sm_ready = 1'b0;
  logic        y_last;

  int tests = 0;
  int fails = 0;

  fir_seq_ctrl #(.NUM_TAPS(N), .ADDR_WIDTH(12)) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .ap_start(ap_start),
    .data_length(data_length),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .ss_valid(ss_valid),
    .ss_ready(ss_ready),
    .data_we(data_we),
    .data_zero(data_zero),
    .data_a(data_a),
    .tap_a(tap_a),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .y_valid(y_valid),
    .sm_ready(sm_ready),
    .y_last(y_last)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".idle"}, 32'(ap_idle), 1);
    chk({tag, ".done"}, 32'(ap_done), 0);
    chk({tag, ".ss_ready"}, 32'(ss_ready), 0);
    chk({tag, ".we"}, 32'(data_we), 0);
    chk({tag, ".zero"}, 32'(data_zero), 0);
    chk({tag, ".data_a"}, 32'(data_a), 0);
    chk({tag, ".tap_a"}, 32'(tap_a), 0);
    chk({tag, ".mac_en"}, 32'(mac_en), 0);
    chk({tag, ".mac_clr"}, 32'(mac_clr), 0);
    chk({tag, ".y_valid"}, 32'(y_valid), 0);
    chk({tag, ".y_last"}, 32'(y_last), 0);
  endtask

  // Pulse ap_start in IDLE, then check every CLEAR cycle.
  task automatic start_clear(input int len);
    data_length = 32'(len);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk("start.idle", 32'(ap_idle), 0);
    chk("start.done", 32'(ap_done), 0);
    for (int i = 0; i < N; i++) begin
      #1;
      chk("clr.we", 32'(data_we), 1);
      chk("clr.zero", 32'(data_zero), 1);
      chk("clr.data_a", 32'(data_a), 32'(4 * i));
      chk("clr.ss_ready", 32'(ss_ready), 0);
      tick();
    end
  endtask

  // One sample: accept, MAC sweep, drain, output with optional
  // stall; poke pulses ap_start in MAC and in OUT.
  task automatic do_sample(input int hp, input bit last,
                           input int stall, input bit poke);
    #1;
    chk("win.ss_ready", 32'(ss_ready), 1);
    chk("win.we_idle", 32'(data_we), 0);
    chk("win.y_valid", 32'(y_valid), 0);
    ss_valid = 1'b1;
    #1;
    chk("win.we", 32'(data_we), 1);
    chk("win.data_a", 32'(data_a), 32'(4 * hp));
    tick();
    ss_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      chk("mac.tap_a", 32'(tap_a), 32'(4 * k));
      chk("mac.data_a", 32'(data_a),
          32'(4 * ((hp - k + N) % N)));
      chk("mac.en", 32'(mac_en), (k > 0) ? 1 : 0);
      chk("mac.clr", 32'(mac_clr), (k == 1) ? 1 : 0);
      chk("mac.ss_ready", 32'(ss_ready), 0);
      chk("mac.idle", 32'(ap_idle), 0);
      if (poke && k == 5) begin
        data_length = 32'd2;
        ap_start = 1'b1;
      end
      tick();
      ap_start = 1'b0;
    end
    #1;
    chk("drain.en", 32'(mac_en), 1);
    chk("drain.clr", 32'(mac_clr), 0);
    chk("drain.y_valid", 32'(y_valid), 0);
    tick();
    #1;
    chk("out.y_valid", 32'(y_valid), 1);
    chk("out.y_last", 32'(y_last), 32'(last));
    chk("out.mac_en", 32'(mac_en), 0);
    for (int s = 0; s < stall; s++) begin
      sm_ready = 1'b0;
      if (poke && s == 0) ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      #1;
      chk("stall.y_valid", 32'(y_valid), 1);
      chk("stall.ss_ready", 32'(ss_ready), 0);
      chk("stall.y_last", 32'(y_last), 32'(last));
    end
    sm_ready = 1'b1;
    tick();
    sm_ready = 1'b0;
    chk("hs.y_valid", 32'(y_valid), 0);
  endtask

  // Runs the DONE cycle and checks the sticky idle/done pair.
  task automatic finish_run;
    #1;
    chk("done.ss_ready", 32'(ss_ready), 0);
    chk("done.y_valid", 32'(y_valid), 0);
    tick();
    chk("fin.done", 32'(ap_done), 1);
    chk("fin.idle", 32'(ap_idle), 1);
    tick();
    chk("fin.done_hold", 32'(ap_done), 1);
  endtask

  initial begin
    ARESET = 1'b0;
    tick();
    tick();
    tick();
    chk_rst("rst");

    ARESET = 1'b1;
    tick();
    chk_rst("post_rst");

    // Three samples, y_last only on the third.
    start_clear(3);
    do_sample(0, 1'b0, 0, 1'b0);
    do_sample(1, 1'b0, 0, 1'b0);
    do_sample(2, 1'b1, 0, 1'b0);
    finish_run();

    // Thirteen samples: stall, ignored starts, buffer wrap.
    start_clear(13);
    for (int s = 0; s < 13; s++) begin
      do_sample(s % N, (s == 12), (s == 1) ? 7 : 0,
                (s == 2));
    end
    finish_run();

    // Zero length: clear then done, no stream activity.
    start_clear(0);
    finish_run();

    // Reset in the middle of a MAC sweep.
    start_clear(3);
    #1;
    ss_valid = 1'b1;
    tick();
    ss_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("pre_rst.tap_a", 32'(tap_a), 32'(4 * 5));
    ARESET = 1'b0;
    tick();
    chk_rst("mid_rst");
    ARESET = 1'b1;
    tick();
    chk_rst("mid_rst_rel");
    start_clear(1);
    do_sample(0, 1'b1, 0, 1'b0);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
